// File: rtl/bcd_clock_counter.sv
// BCD time-of-day counter with 1 Hz tick input, RUN/PAUSE/SET modes and key-driven time setting.
`timescale 1ns/1ps

module bcd_clock_counter #(
   parameter int unsigned HOUR_MAX = 23
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tick_in,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       key_pause,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [1:0] mode,
   output logic       sec_pulse,
   output logic       day_wrap
);

   localparam logic [1:0] ST_RUN      = 2'b00;
   localparam logic [1:0] ST_PAUSE    = 2'b01;
   localparam logic [1:0] ST_SET_HOUR = 2'b10;
   localparam logic [1:0] ST_SET_MIN  = 2'b11;

   localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
   localparam logic [7:0] MS_MAX_BCD   = 8'h59;

   // Two-digit BCD increment; returns {wrapped, next_value}, each digit stays in 0..9
   function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
      logic [8:0] r;
      if (v == vmax) begin
         r = 9'h100;
      end else if (v[3:0] == 4'd9) begin
         r = {1'b0, v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {1'b0, v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   logic       r_sync1;
   logic       r_sync2;
   logic       r_prev;
   logic [1:0] r_fill;
   logic       r_armed;
   logic [1:0] r_mode;
   logic [7:0] r_hour;
   logic [7:0] r_min;
   logic [7:0] r_sec;
   logic       r_sec_pulse;
   logic       r_day_wrap;

   logic       w_tick;
   logic [1:0] w_mode_nxt;
   logic [7:0] w_hour_nxt;
   logic [7:0] w_min_nxt;
   logic [7:0] w_sec_nxt;
   logic       w_pulse_nxt;
   logic       w_wrap_nxt;
   logic [8:0] w_sec_inc;
   logic [8:0] w_min_inc;
   logic [8:0] w_hour_inc;

   // Tick edge only counts once the synchronizer holds real data that has been seen low
   assign w_tick = r_armed & r_sync2 & ~r_prev;

   // Synchronizer, previous-value register and arming logic for tick_in
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_fill  <= 2'b00;
         r_armed <= 1'b0;
      end else begin
         r_sync1 <= tick_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_fill  <= {r_fill[0], 1'b1};
         r_armed <= r_armed | (r_fill[1] & ~r_sync2);
      end
   end

   // State and time registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mode      <= ST_RUN;
         r_hour      <= 8'h00;
         r_min       <= 8'h00;
         r_sec       <= 8'h00;
         r_sec_pulse <= 1'b0;
         r_day_wrap  <= 1'b0;
      end else begin
         r_mode      <= w_mode_nxt;
         r_hour      <= w_hour_nxt;
         r_min       <= w_min_nxt;
         r_sec       <= w_sec_nxt;
         r_sec_pulse <= w_pulse_nxt;
         r_day_wrap  <= w_wrap_nxt;
      end
   end

   // Next state: tick counting in RUN, then keys with key_mode > key_pause > key_inc
   always_comb begin
      w_mode_nxt  = r_mode;
      w_hour_nxt  = r_hour;
      w_min_nxt   = r_min;
      w_sec_nxt   = r_sec;
      w_pulse_nxt = 1'b0;
      w_wrap_nxt  = 1'b0;
      w_sec_inc   = bcd_inc(r_sec, MS_MAX_BCD);
      w_min_inc   = bcd_inc(r_min, MS_MAX_BCD);
      w_hour_inc  = bcd_inc(r_hour, HOUR_MAX_BCD);

      if (w_tick && (r_mode == ST_RUN)) begin
         w_pulse_nxt = 1'b1;
         w_sec_nxt   = w_sec_inc[7:0];
         if (w_sec_inc[8]) begin
            w_min_nxt = w_min_inc[7:0];
            if (w_min_inc[8]) begin
               w_hour_nxt = w_hour_inc[7:0];
               w_wrap_nxt = w_hour_inc[8];
            end
         end
      end

      if (key_mode) begin
         case (r_mode)
            ST_RUN, ST_PAUSE: w_mode_nxt = ST_SET_HOUR;
            ST_SET_HOUR:      w_mode_nxt = ST_SET_MIN;
            default: begin
               w_mode_nxt = ST_RUN;
               w_sec_nxt  = 8'h00;
            end
         endcase
      end else if (key_pause) begin
         if (r_mode == ST_RUN) begin
            w_mode_nxt = ST_PAUSE;
         end else if (r_mode == ST_PAUSE) begin
            w_mode_nxt = ST_RUN;
         end
      end else if (key_inc) begin
         if (r_mode == ST_SET_HOUR) begin
            w_hour_nxt = w_hour_inc[7:0];
         end else if (r_mode == ST_SET_MIN) begin
            w_min_nxt = w_min_inc[7:0];
         end
      end
   end

   assign hour_bcd  = r_hour;
   assign min_bcd   = r_min;
   assign sec_bcd   = r_sec;
   assign mode      = r_mode;
   assign sec_pulse = r_sec_pulse;
   assign day_wrap  = r_day_wrap;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Testbench for bcd_clock_counter: seconds-of-day model checked every cycle plus directed literal checks.
`timescale 1ns/1ps

module tb_bcd_clock_counter;

   localparam int HMAX = 23;

   logic       clk;
   logic       rstn;
   logic       tick_in;
   logic       key_mode;
   logic       key_inc;
   logic       key_pause;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic [1:0] mode;
   logic       sec_pulse;
   logic       day_wrap;

   int n_checks = 0;
   int n_errors = 0;
   int n_pulse  = 0;
   int n_wrap   = 0;
   int n_wrap_p = 0;

   bcd_clock_counter #(.HOUR_MAX(HMAX)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .tick_in   (tick_in),
      .key_mode  (key_mode),
      .key_inc   (key_inc),
      .key_pause (key_pause),
      .hour_bcd  (hour_bcd),
      .min_bcd   (min_bcd),
      .sec_bcd   (sec_bcd),
      .mode      (mode),
      .sec_pulse (sec_pulse),
      .day_wrap  (day_wrap)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Model state: time kept as plain integers, tick seen 3 edges after its rise
   int       m_h, m_m, m_s, m_mode, m_old, m_t;
   bit       m_pulse, m_wrap, m_prev_t, m_rise, m_tk;
   bit [1:0] m_pend;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model of the clock
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
         m_pulse = 0; m_wrap = 0; m_prev_t = 1; m_pend = 2'b00;
      end else begin
         m_rise   = tick_in && !m_prev_t;
         m_prev_t = tick_in;
         m_tk     = m_pend[1];
         m_pend   = {m_pend[0], m_rise};
         m_old    = m_mode;
         m_pulse  = 0;
         m_wrap   = 0;
         if (m_tk && m_old == 0) begin
            m_pulse = 1;
            m_t = m_h * 3600 + m_m * 60 + m_s + 1;
            if (m_t == (HMAX + 1) * 3600) begin
               m_t = 0;
               m_wrap = 1;
            end
            m_h = m_t / 3600;
            m_m = (m_t / 60) % 60;
            m_s = m_t % 60;
         end
         if (key_mode) begin
            if (m_old == 0 || m_old == 1) m_mode = 2;
            else if (m_old == 2)          m_mode = 3;
            else begin
               m_mode = 0;
               m_s = 0;
            end
         end else if (key_pause) begin
            if (m_old == 0)      m_mode = 1;
            else if (m_old == 1) m_mode = 0;
         end else if (key_inc) begin
            if (m_old == 2)      m_h = (m_h + 1) % (HMAX + 1);
            else if (m_old == 3) m_m = (m_m + 1) % 60;
         end
      end
   end

   // Per-cycle compare against the model and pulse bookkeeping
   always @(negedge clk) begin
      chk("hour",  32'(hour_bcd),  32'(to_bcd(m_h)));
      chk("min",   32'(min_bcd),   32'(to_bcd(m_m)));
      chk("sec",   32'(sec_bcd),   32'(to_bcd(m_s)));
      chk("mode",  32'(mode),      32'(m_mode));
      chk("pulse", 32'(sec_pulse), 32'(m_pulse));
      chk("wrap",  32'(day_wrap),  32'(m_wrap));
      if (sec_pulse === 1'b1) n_pulse++;
      if (day_wrap === 1'b1) n_wrap++;
      if (day_wrap === 1'b1 && sec_pulse === 1'b1) n_wrap_p++;
   end

   // Key index: 0 mode, 1 inc, 2 pause
   task automatic press(input int k);
      @(negedge clk);
      case (k)
         0: key_mode = 1'b1;
         1: key_inc = 1'b1;
         default: key_pause = 1'b1;
      endcase
      @(negedge clk);
      key_mode = 1'b0;
      key_inc = 1'b0;
      key_pause = 1'b0;
   endtask

   task automatic press_n(input int k, input int n);
      for (int i = 0; i < n; i++) press(k);
   endtask

   task automatic tick();
      tick_in = 1'b0;
      repeat (60) @(negedge clk);
      tick_in = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   // One tick with explicit latency check: sec_pulse must first appear after the 3rd edge
   task automatic tick_latency();
      tick_in = 1'b0;
      repeat (60) @(negedge clk);
      tick_in = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("latency", 32'(sec_pulse), (k == 3) ? 32'd1 : 32'd0);
      end
      repeat (57) @(negedge clk);
   endtask

   // Tick whose counting edge coincides with a key press (0 mode, 2 pause)
   task automatic tick_with_key(input int k);
      tick_in = 1'b0;
      repeat (60) @(negedge clk);
      tick_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (k == 0) key_mode = 1'b1;
      else        key_pause = 1'b1;
      @(negedge clk);
      key_mode = 1'b0;
      key_pause = 1'b0;
      repeat (57) @(negedge clk);
   endtask

   int p0, w0, wp0;

   initial begin
      rstn = 1'b0;
      tick_in = 1'b0;
      key_mode = 1'b0;
      key_inc = 1'b0;
      key_pause = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_hour", 32'(hour_bcd), 32'h00);
      chk("rst_sec",  32'(sec_bcd),  32'h00);
      chk("rst_mode", 32'(mode),     32'h0);
      rstn = 1'b1;
      repeat (10) @(negedge clk);

      // Three ticks from reset
      p0 = n_pulse;
      repeat (3) tick_latency();
      chk("three_ticks_sec", 32'(sec_bcd), 32'h03);
      chk("three_ticks_cnt", 32'(n_pulse - p0), 32'd3);

      // Pause discards ticks
      press(2);
      chk("paused_mode", 32'(mode), 32'h1);
      repeat (5) tick();
      chk("paused_sec", 32'(sec_bcd), 32'h03);
      press(2);
      chk("resumed_mode", 32'(mode), 32'h0);
      tick();
      chk("resumed_sec", 32'(sec_bcd), 32'h04);

      // Set sequence with wrap in both fields
      press(0);
      press_n(1, 25);
      press(0);
      press_n(1, 61);
      press(0);
      chk("set_hour", 32'(hour_bcd), 32'h01);
      chk("set_min",  32'(min_bcd),  32'h01);
      chk("set_sec",  32'(sec_bcd),  32'h00);
      chk("set_mode", 32'(mode),     32'h0);

      // key_mode wins over simultaneous key_inc
      press(0);
      @(negedge clk);
      key_mode = 1'b1;
      key_inc = 1'b1;
      @(negedge clk);
      key_mode = 1'b0;
      key_inc = 1'b0;
      chk("prio_mode", 32'(mode), 32'h3);
      chk("prio_hour", 32'(hour_bcd), 32'h01);
      press(0);

      // Tick coinciding with key_pause / key_mode in RUN
      tick_with_key(2);
      chk("tick_pause_sec",  32'(sec_bcd), 32'h01);
      chk("tick_pause_mode", 32'(mode),    32'h1);
      press(2);
      tick_with_key(0);
      chk("tick_mode_sec",  32'(sec_bcd), 32'h02);
      chk("tick_mode_mode", 32'(mode),    32'h2);
      press(0);
      press(0);
      chk("clear_sec", 32'(sec_bcd), 32'h00);

      // Preset 23:59:59 then day wrap
      press(0);
      press_n(1, 22);
      press(0);
      press_n(1, 58);
      press(0);
      repeat (59) tick();
      chk("pre_hour", 32'(hour_bcd), 32'h23);
      chk("pre_min",  32'(min_bcd),  32'h59);
      chk("pre_sec",  32'(sec_bcd),  32'h59);
      p0 = n_pulse;
      w0 = n_wrap;
      wp0 = n_wrap_p;
      tick();
      chk("wrap_hour",  32'(hour_bcd), 32'h00);
      chk("wrap_min",   32'(min_bcd),  32'h00);
      chk("wrap_sec",   32'(sec_bcd),  32'h00);
      chk("wrap_cnt",   32'(n_wrap - w0),    32'd1);
      chk("wrap_coinc", 32'(n_wrap_p - wp0), 32'd1);
      chk("wrap_pulse", 32'(n_pulse - p0),   32'd1);

      // Async reset inside SET_HOUR with a tick in flight, tick held high across release
      press(0);
      press_n(1, 5);
      tick_in = 1'b0;
      repeat (60) @(negedge clk);
      tick_in = 1'b1;
      @(negedge clk);
      #3 rstn = 1'b0;
      #1;
      chk("async_mode", 32'(mode),     32'h0);
      chk("async_hour", 32'(hour_bcd), 32'h00);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      p0 = n_pulse;
      repeat (100) @(negedge clk);
      chk("held_high_pulses", 32'(n_pulse - p0), 32'd0);
      tick();
      chk("first_real_pulse", 32'(n_pulse - p0), 32'd1);
      chk("first_real_sec",   32'(sec_bcd),      32'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bcd_clock_counter.md
BCD_CLOCK_COUNTER -- requirements
Module: bcd_clock_counter

Interface
REQ-001 Parameter HOUR_MAX, default 23, sets the largest hour value before wrap to 00; the legal range is 1..23.
REQ-002 clk  input  1  system clock, 50 MHz (20 ns).
REQ-003 rstn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 tick_in  input  1  1 Hz square wave from the 1 s divider; each rising edge is one second; asynchronous to clk.
REQ-005 key_mode  input  1  debounced single-cycle pulse that advances the mode.
REQ-006 key_inc  input  1  debounced single-cycle pulse that increments the field being set.
REQ-007 key_pause  input  1  debounced single-cycle pulse that toggles RUN/PAUSE.
REQ-008 hour_bcd  output  8  hours as two BCD digits, tens in [7:4].
REQ-009 min_bcd  output  8  minutes as two BCD digits.
REQ-010 sec_bcd  output  8  seconds as two BCD digits.
REQ-011 mode  output  2  current state: 00 RUN, 01 PAUSE, 10 SET_HOUR, 11 SET_MIN.
REQ-012 sec_pulse  output  1  one-cycle pulse on every second actually counted.
REQ-013 day_wrap  output  1  one-cycle pulse when the time wraps from HOUR_MAX:59:59 to 00:00:00.

Function
REQ-014 tick_in shall pass through a 2-FF synchronizer, followed by a previous-value register.
REQ-015 A tick event shall be sync2=1 while prev=0; the counters shall update on the 3rd rising clk edge after tick_in rises.
REQ-016 The edge detector shall be armed only after sync2 has been seen low after reset, so a tick_in held high through reset release is not counted.
REQ-017 A tick event in RUN shall increment sec and assert sec_pulse in the same cycle; tick events in all other states shall be discarded and not accumulated.
REQ-018 Seconds: 59 -> 00 with carry into minutes; minutes: 59 -> 00 with carry into hours; hours: HOUR_MAX -> 00.
REQ-019 day_wrap shall assert only on the full HOUR_MAX:59:59 -> 00:00:00 transition.
REQ-020 Every BCD digit shall stay in 0..9 at all times; binary arithmetic across the digit boundary is forbidden.
REQ-021 FSM, mode transitions: RUN --key_mode--> SET_HOUR; PAUSE --key_mode--> SET_HOUR; SET_HOUR --key_mode--> SET_MIN; SET_MIN --key_mode--> RUN.
REQ-022 FSM, pause transitions: RUN --key_pause--> PAUSE; PAUSE --key_pause--> RUN; key_pause is ignored in SET_HOUR and SET_MIN.
REQ-023 The SET_MIN -> RUN transition shall clear sec_bcd to 00 on the same clock edge.
REQ-024 key_inc in SET_HOUR shall increment hours, wrapping HOUR_MAX -> 00, with no day_wrap.
REQ-025 key_inc in SET_MIN shall increment minutes, wrapping 59 -> 00, with no carry into hours.
REQ-026 key_inc shall be ignored in RUN and PAUSE.
REQ-027 Simultaneous keys: key_mode has priority; a key_inc or key_pause in the same cycle is ignored.
REQ-028 A tick event and key_pause in the same RUN cycle: the tick shall be counted, and the next state is PAUSE.
REQ-029 A tick event and key_mode in the same RUN cycle: the tick shall be counted, and the next state is SET_HOUR.
REQ-030 All outputs shall be registered, with no combinational path from inputs to outputs.

Reset
REQ-031 rstn low shall clear asynchronously: hour/min/sec_bcd = 00, mode = 00 (RUN), sec_pulse = 0, day_wrap = 0.
REQ-032 rstn low shall also clear the synchronizer, prev register and arm flag to 0.
REQ-033 Reset asserted mid-operation, including inside SET states, shall take effect immediately and discard any pending edge.
REQ-034 After rstn deassertion the block shall resume normal operation on the next clk edge, with no extra idle cycles beyond REQ-016.

Verification
REQ-035 Reset, then toggle tick_in 3 times (low then high, 60 clk per half period) -> sec_bcd = 0x03, three sec_pulse, and each update exactly 3 clk after its tick_in rise.
REQ-036 Preset 23:59:59 via SET keys plus ticks, apply one tick -> 00:00:00 and a single day_wrap pulse coincident with sec_pulse.
REQ-037 In RUN send key_pause, apply 5 ticks, send key_pause, apply 1 tick -> sec_bcd advances by exactly 1 and mode goes 00 -> 01 -> 00.
REQ-038 Set sequence: key_mode, key_inc x25, key_mode, key_inc x61, key_mode -> hour 0x01, min 0x01, sec 0x00, mode 00.
REQ-039 Hold tick_in high across rstn release -> no sec_pulse until the next genuine rising edge.
REQ-040 Assert key_mode and key_inc in the same cycle in SET_HOUR -> mode = SET_MIN and hours unchanged.
